uart_rx_sequencer: RTL and testbench

UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_rx_sequencer.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_pkg                                               |
// | Brief   : Shared state encoding and defaults for the UART rx.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package uart_pkg;

    localparam int c_DATA_BITS = 8;
    localparam int c_MIN_DIV   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_bit_timer                                         |
// | Brief   : 16-bit bit-period counter with half/full-bit ticks.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_bit_timer (
    input  logic        BRGCLK,
    input  logic        rst,
    input  logic        i_clr,
    input  logic [15:0] i_n,
    output logic        o_half_tick,
    output logic        o_full_tick
);

    logic [15:0] r_count;

    always_ff @(posedge BRGCLK or posedge rst) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (i_clr) begin
            r_count <= 16'd0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    // i_n is never below MIN_DIV, so neither terminal count underflows.
    assign o_half_tick = (r_count == ((i_n >> 1) - 16'd1));
    assign o_full_tick = (r_count == (i_n - 16'd1));

endmodule
`default_nettype wire

// File: rtl/uart_rx_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_rx_sequencer                                      |
// | Brief   : UART receive FSM, shifter, holding register and flags. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = c_DATA_BITS,
    parameter int MIN_DIV   = c_MIN_DIV
) (
    input  logic                 BRGCLK,
    input  logic                 rst,
    input  logic                 UxRX,
    input  logic                 rx_en,
    input  logic [15:0]          baud_div,
    input  logic                 rd,
    input  logic                 clr_err,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 UxRXIF,
    output logic                 FERR,
    output logic                 OERR,
    output logic                 busy
);

    localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    logic [15:0]          r_n;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rxif;
    logic                 r_ferr;
    logic                 r_oerr;
    logic                 r_busy;

    logic                 w_fall;
    logic [15:0]          w_n_eff;
    logic                 w_half;
    logic                 w_full;
    logic                 w_cnt_clr;

    always_ff @(posedge BRGCLK or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= UxRX;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_fall  = r_rx_prev & ~r_rx_s;
    assign w_n_eff = (baud_div < 16'(MIN_DIV)) ? 16'(MIN_DIV) : baud_div;

    // Counter restarts at every sample point and is parked at zero in IDLE.
    assign w_cnt_clr = !rx_en
                    || (r_state == ST_IDLE)
                    || ((r_state == ST_START) && w_half)
                    || (((r_state == ST_DATA) || (r_state == ST_STOP)) && w_full);

    uart_bit_timer u_bit_timer (
        .BRGCLK      (BRGCLK),
        .rst         (rst),
        .i_clr       (w_cnt_clr),
        .i_n         (r_n),
        .o_half_tick (w_half),
        .o_full_tick (w_full)
    );

    always_ff @(posedge BRGCLK or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_n       <= 16'(MIN_DIV);
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_rx_data <= '0;
            r_rxif    <= 1'b0;
            r_ferr    <= 1'b0;
            r_oerr    <= 1'b0;
        end else begin
            // Clears come first so a same-cycle set below takes priority.
            if (clr_err) begin
                r_ferr <= 1'b0;
                r_oerr <= 1'b0;
            end
            if (rd) begin
                r_rxif <= 1'b0;
            end

            if (!rx_en) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_fall) begin
                            r_state <= ST_START;
                            r_busy  <= 1'b1;
                            r_n     <= w_n_eff;
                        end
                    end
                    ST_START: begin
                        if (w_half) begin
                            if (!r_rx_s) begin
                                r_state   <= ST_DATA;
                                r_bit_idx <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_full) begin
                            r_shift   <= DATA_BITS'({r_rx_s, r_shift} >> 1);
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                            if (r_bit_idx == c_IDX_W'(DATA_BITS - 1)) begin
                                r_state <= ST_STOP;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (w_full) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            if (!r_rx_s) begin
                                r_ferr <= 1'b1;
                            end
                            if (!r_rxif || rd) begin
                                r_rx_data <= r_shift;
                                r_rxif    <= 1'b1;
                            end else begin
                                r_oerr <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data = r_rx_data;
    assign UxRXIF  = r_rxif;
    assign FERR    = r_ferr;
    assign OERR    = r_oerr;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_uart_rx_sequencer                                   |
// | Brief   : Directed self-checking bench for uart_rx_sequencer.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_uart_rx_sequencer;

    logic        BRGCLK = 1'b0;
    logic        rst;
    logic        UxRX;
    logic        rx_en;
    logic [15:0] baud_div;
    logic        rd;
    logic        clr_err;
    logic [7:0]  rx_data;
    logic        UxRXIF;
    logic        FERR;
    logic        OERR;
    logic        busy;

    int err_cnt = 0;
    int chk_cnt = 0;

    uart_rx_sequencer dut (
        .BRGCLK   (BRGCLK),
        .rst      (rst),
        .UxRX     (UxRX),
        .rx_en    (rx_en),
        .baud_div (baud_div),
        .rd       (rd),
        .clr_err  (clr_err),
        .rx_data  (rx_data),
        .UxRXIF   (UxRXIF),
        .FERR     (FERR),
        .OERR     (OERR),
        .busy     (busy)
    );

    always #5 BRGCLK = ~BRGCLK;

    task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge BRGCLK);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge BRGCLK);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge BRGCLK);
        clr_err = 1'b0;
    endtask

    // Drives one frame at n cycles per bit, starting and ending on a negedge.
    // rd_dlv pulses rd on the cycle of the stop-bit sample (start + n/2 + 3 + 9n edges).
    // abort_mode 1 = rst, 2 = rx_en low, fired mid data bit abort_bit.
    task automatic send_frame(input logic [7:0] d, input logic stopb, input int n,
                              input bit rd_dlv, input int abort_bit, input int abort_mode);
        logic [9:0] f;
        f = {stopb, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            UxRX = f[b];
            for (int c = 1; c <= n; c++) begin
                @(negedge BRGCLK);
                if (b == 9) rd = rd_dlv && (c == n / 2 + 2);
                if (abort_mode != 0 && b == abort_bit + 1 && c == n / 2) begin
                    chk_eq("busy_mid_frame", 16'(busy), 16'd1);
                    if (abort_mode == 1) begin
                        rst = 1'b1;
                        #1;
                        chk_eq("busy_after_rst", 16'(busy), 16'd0);
                        @(negedge BRGCLK);
                        rst = 1'b0;
                    end else begin
                        rx_en = 1'b0;
                        @(negedge BRGCLK);
                        chk_eq("busy_after_en0", 16'(busy), 16'd0);
                        rx_en = 1'b1;
                    end
                    UxRX = 1'b1;
                    return;
                end
            end
        end
        rd = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; UxRX = 1'b1; rx_en = 1'b0; baud_div = 16'd16; rd = 1'b0; clr_err = 1'b0;
        wait_cyc(3);
        chk_eq("rst_rx_data", 16'(rx_data), 16'h00);
        chk_eq("rst_rxif", 16'(UxRXIF), 16'd0);
        chk_eq("rst_ferr", 16'(FERR), 16'd0);
        chk_eq("rst_oerr", 16'(OERR), 16'd0);
        chk_eq("rst_busy", 16'(busy), 16'd0);
        rst = 1'b0; rx_en = 1'b1;
        wait_cyc(4);

        // Clean frame at N=16
        send_frame(8'hA5, 1'b1, 16, 1'b0, 0, 0);
        wait_cyc(4);
        chk_eq("a5_data", 16'(rx_data), 16'hA5);
        chk_eq("a5_rxif", 16'(UxRXIF), 16'd1);
        chk_eq("a5_ferr", 16'(FERR), 16'd0);
        chk_eq("a5_oerr", 16'(OERR), 16'd0);
        chk_eq("a5_busy", 16'(busy), 16'd0);
        pulse_rd();
        chk_eq("rd_clears_rxif", 16'(UxRXIF), 16'd0);
        pulse_rd();
        chk_eq("rd_idle_ignored", 16'(UxRXIF), 16'd0);

        // baud_div below the floor runs at N=4
        baud_div = 16'd2;
        send_frame(8'h3C, 1'b1, 4, 1'b0, 0, 0);
        wait_cyc(4);
        chk_eq("3c_data", 16'(rx_data), 16'h3C);
        chk_eq("3c_rxif", 16'(UxRXIF), 16'd1);
        pulse_rd();
        baud_div = 16'd16;
        wait_cyc(4);

        // Short low glitch is rejected at the half-bit sample
        UxRX = 1'b0;
        wait_cyc(4);
        chk_eq("glitch_busy_start", 16'(busy), 16'd1);
        UxRX = 1'b1;
        wait_cyc(30);
        chk_eq("glitch_busy_end", 16'(busy), 16'd0);
        chk_eq("glitch_rxif", 16'(UxRXIF), 16'd0);
        chk_eq("glitch_ferr", 16'(FERR), 16'd0);
        chk_eq("glitch_oerr", 16'(OERR), 16'd0);

        // Framing error, line then held low
        send_frame(8'h55, 1'b0, 16, 1'b0, 0, 0);
        wait_cyc(4);
        chk_eq("55_data", 16'(rx_data), 16'h55);
        chk_eq("55_ferr", 16'(FERR), 16'd1);
        chk_eq("55_rxif", 16'(UxRXIF), 16'd1);
        pulse_rd();
        wait_cyc(300);
        chk_eq("break_busy", 16'(busy), 16'd0);
        chk_eq("break_rxif", 16'(UxRXIF), 16'd0);
        UxRX = 1'b1;
        wait_cyc(4);
        pulse_clr();
        chk_eq("clr_ferr", 16'(FERR), 16'd0);

        // Overrun: second byte discarded
        send_frame(8'h11, 1'b1, 16, 1'b0, 0, 0);
        wait_cyc(4);
        send_frame(8'h22, 1'b1, 16, 1'b0, 0, 0);
        wait_cyc(4);
        chk_eq("ovr_data", 16'(rx_data), 16'h11);
        chk_eq("ovr_oerr", 16'(OERR), 16'd1);
        chk_eq("ovr_rxif", 16'(UxRXIF), 16'd1);
        pulse_clr();
        chk_eq("clr_oerr", 16'(OERR), 16'd0);

        // Same again with rd coincident with delivery
        send_frame(8'h22, 1'b1, 16, 1'b1, 0, 0);
        wait_cyc(4);
        chk_eq("rdd_data", 16'(rx_data), 16'h22);
        chk_eq("rdd_oerr", 16'(OERR), 16'd0);
        chk_eq("rdd_rxif", 16'(UxRXIF), 16'd1);
        pulse_rd();

        // rst at data bit 4, then a clean frame
        send_frame(8'h00, 1'b1, 16, 1'b0, 4, 1);
        wait_cyc(200);
        chk_eq("rst_abort_rxif", 16'(UxRXIF), 16'd0);
        chk_eq("rst_abort_data", 16'(rx_data), 16'h00);
        send_frame(8'h7E, 1'b1, 16, 1'b0, 0, 0);
        wait_cyc(4);
        chk_eq("7e_data_a", 16'(rx_data), 16'h7E);
        chk_eq("7e_rxif_a", 16'(UxRXIF), 16'd1);
        pulse_rd();

        // rx_en low at data bit 4: holding register untouched
        send_frame(8'h00, 1'b1, 16, 1'b0, 4, 2);
        wait_cyc(200);
        chk_eq("en_abort_rxif", 16'(UxRXIF), 16'd0);
        chk_eq("en_abort_data", 16'(rx_data), 16'h7E);
        send_frame(8'h7E, 1'b1, 16, 1'b0, 0, 0);
        wait_cyc(4);
        chk_eq("7e_rxif_b", 16'(UxRXIF), 16'd1);
        chk_eq("7e_ferr_b", 16'(FERR), 16'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
